// File: rtl/sa_stream_feeder_pkg.sv
// Shared constants and FSM encoding for the systolic-array stream feeder.
package sa_stream_feeder_pkg;

    localparam int unsigned WEIGHT_COUNT = 9;
    localparam int unsigned DATA_W       = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2,
        StDone   = 2'd3
    } state_e;

endpackage

// File: rtl/sa_skew_line.sv
// Fixed-depth 8-bit delay line with asynchronous clear and an all-stages-zero flag.
module sa_skew_line
    import sa_stream_feeder_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] stage_q [Depth];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(Depth); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= din_i;
            for (int i = 1; i < int'(Depth); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    always_comb begin
        empty_o = 1'b1;
        for (int i = 0; i < int'(Depth); i++) begin
            if (stage_q[i] != '0) begin
                empty_o = 1'b0;
            end
        end
    end

    assign dout_o = stage_q[Depth-1];

endmodule

// File: rtl/sa_stream_feeder.sv
// Host-side feeder for the 3x3 systolic array: holds weights, skews subject vectors into
// the row inputs and tags accepted vectors so their results come back with result_valid.
module sa_stream_feeder
    import sa_stream_feeder_pkg::*;
#(
    parameter int unsigned RESULT_LATENCY = 5,
    parameter int unsigned ROW_SKEW       = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                weight_we,
    input  logic [3:0]          weight_addr,
    input  logic [DATA_W-1:0]   weight_data,
    input  logic                start,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [3*DATA_W-1:0] vec_data,
    input  logic                vec_last,
    output logic [DATA_W-1:0]   weight_out_1_1,
    output logic [DATA_W-1:0]   weight_out_1_2,
    output logic [DATA_W-1:0]   weight_out_1_3,
    output logic [DATA_W-1:0]   weight_out_2_1,
    output logic [DATA_W-1:0]   weight_out_2_2,
    output logic [DATA_W-1:0]   weight_out_2_3,
    output logic [DATA_W-1:0]   weight_out_3_1,
    output logic [DATA_W-1:0]   weight_out_3_2,
    output logic [DATA_W-1:0]   weight_out_3_3,
    output logic [DATA_W-1:0]   subject_out_1,
    output logic [DATA_W-1:0]   subject_out_2,
    output logic [DATA_W-1:0]   subject_out_3,
    input  logic [DATA_W-1:0]   sa_result,
    output logic                result_valid,
    output logic [DATA_W-1:0]   result_data,
    output logic                busy,
    output logic                done
);

    localparam int unsigned TagDepth = 1 + RESULT_LATENCY;

    state_e              state_q, state_d;
    logic                vec_ready_q, busy_q, done_q;
    logic [TagDepth-1:0] tag_q;
    logic [DATA_W-1:0]   weight_q [WEIGHT_COUNT];
    logic [DATA_W-1:0]   subj_q   [3];
    logic [DATA_W-1:0]   row1_in, row2_in, row3_in, row2_out, row3_out;
    logic                row2_empty, row3_empty, hs, weight_wr;

    assign hs        = vec_valid & vec_ready_q;
    assign weight_wr = weight_we && (state_q == StIdle) && (32'(weight_addr) < WEIGHT_COUNT);

    // Idle cycles inject zeros so the array sees clean bubbles.
    assign row1_in = hs ? vec_data[DATA_W-1:0]          : '0;
    assign row2_in = hs ? vec_data[2*DATA_W-1:DATA_W]   : '0;
    assign row3_in = hs ? vec_data[3*DATA_W-1:2*DATA_W] : '0;

    sa_skew_line #(.Depth(ROW_SKEW)) u_row2_line (
        .clk     (clk),
        .reset   (reset),
        .din_i   (row2_in),
        .dout_o  (row2_out),
        .empty_o (row2_empty)
    );

    sa_skew_line #(.Depth(2 * ROW_SKEW)) u_row3_line (
        .clk     (clk),
        .reset   (reset),
        .din_i   (row3_in),
        .dout_o  (row3_out),
        .empty_o (row3_empty)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StStream;
            StStream: if (hs && vec_last) state_d = StDrain;
            // Leave once the final tag is in the last stage, so done follows it directly.
            StDrain:  if (tag_q[TagDepth-2:0] == '0 && row2_empty && row3_empty) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tag_q       <= '0;
            for (int i = 0; i < 3; i++) subj_q[i] <= '0;
            for (int i = 0; i < int'(WEIGHT_COUNT); i++) weight_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            vec_ready_q <= (state_d == StStream);
            busy_q      <= (state_d == StStream) || (state_d == StDrain);
            done_q      <= (state_d == StDone);
            tag_q       <= {tag_q[TagDepth-2:0], hs};
            subj_q[0]   <= row1_in;
            subj_q[1]   <= row2_out;
            subj_q[2]   <= row3_out;
            if (weight_wr) weight_q[weight_addr] <= weight_data;
        end
    end

    assign vec_ready      = vec_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign result_valid   = tag_q[TagDepth-1];
    assign result_data    = sa_result;
    assign subject_out_1  = subj_q[0];
    assign subject_out_2  = subj_q[1];
    assign subject_out_3  = subj_q[2];
    assign weight_out_1_1 = weight_q[0];
    assign weight_out_1_2 = weight_q[1];
    assign weight_out_1_3 = weight_q[2];
    assign weight_out_2_1 = weight_q[3];
    assign weight_out_2_2 = weight_q[4];
    assign weight_out_2_3 = weight_q[5];
    assign weight_out_3_1 = weight_q[6];
    assign weight_out_3_2 = weight_q[7];
    assign weight_out_3_3 = weight_q[8];

endmodule

// File: doc/sa_stream_feeder.md
Name: sa_stream_feeder

Overview:
- Host-side driver for the 3x3 systolic array. It holds the nine 8-bit weights and accepts 3-element subject vectors over a valid/ready stream.
- It skews each vector into the array's three row inputs with a 1-cycle-per-row stagger and zero-fills idle cycles.
- It tags each accepted vector and pairs it with the array's registered result, producing a result_valid strobe.
- Sits between the host/testbench and the array: its weight and subject outputs drive the array inputs, and the array result returns on sa_result.

Parameters:
- RESULT_LATENCY, 5, cycles from subject_out_1 carrying a vector's row-1 element to sa_result carrying that vector's result.
- ROW_SKEW, 1, per-row delay in cycles (row r delayed (r-1)*ROW_SKEW); only 1 is supported, other values are illegal.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- weight_we  in  1  weight write strobe
- weight_addr  in  4  weight index 0..8, row-major (0=w11, 1=w12, ... 8=w33)
- weight_data  in  8  weight value
- start  in  1  begin a stream job
- vec_valid  in  1  host has a vector
- vec_ready  out  1  feeder accepts a vector this cycle
- vec_data  in  24  [7:0]=row1, [15:8]=row2, [23:16]=row3
- vec_last  in  1  qualifies the final vector of the job
- weight_out_1_1 .. weight_out_3_3  out  8 each  registered weights to the array (9 ports)
- subject_out_1, subject_out_2, subject_out_3  out  8 each  skewed row inputs to the array
- sa_result  in  8  array result
- result_valid  out  1  sa_result belongs to an accepted vector
- result_data  out  8  equals sa_result (combinational pass-through)
- busy  out  1  high in STREAM or DRAIN
- done  out  1  one-cycle pulse at job end

Behaviour:
- Reset values: all weight_out = 0, all subject_out = 0, vec_ready = 0, result_valid = 0, busy = 0, done = 0. Delay lines and the tag pipe are cleared, and the FSM goes to IDLE.
- FSM states: IDLE -> STREAM -> DRAIN -> DONE -> IDLE.
  - IDLE -> STREAM: start = 1.
  - STREAM -> DRAIN: handshake with vec_last = 1.
  - DRAIN -> DONE: tag pipe and delay lines are all zero.
  - DONE -> IDLE: unconditional; done = 1 only in DONE.
- Weight writes:
  - Honoured only in IDLE; weight_out updates on the next edge.
  - Ignored when addr > 8 or when not in IDLE.
  - A write and start in the same IDLE cycle: the write takes effect.
- vec_ready = 1 only in STREAM. A handshake occurs on an edge where vec_valid & vec_ready.
- Skew for a handshake at edge k:
  - subject_out_1 = row1 during cycle k+1
  - subject_out_2 = row2 during k+2
  - subject_out_3 = row3 during k+3
- Any cycle without a handshake (bubble, IDLE, DRAIN, DONE) injects 0 into the row1 input and into the row2/row3 delay heads. Delay lines always shift.
- Tag pipe: 1-bit shift register of depth 1+RESULT_LATENCY, loaded with the handshake bit each cycle. result_valid for handshake k is high in cycle k+1+RESULT_LATENCY (default k+6). Back-to-back handshakes produce back-to-back result_valid.
- No result backpressure: the host must consume result_valid when it is asserted.
- start while busy or in DONE is ignored. vec_last outside a handshake is ignored.
- Reset asserted mid-job: immediate clear, pending results are discarded, and no done pulse is produced.
- Job with a single vector (vec_last on the first handshake): goes straight to DRAIN; done falls 1 cycle after the last result_valid.

Decomposition:
- Shared package: WEIGHT_COUNT=9, DATA_W=8, and the state encoding localparams (IDLE, STREAM, DRAIN, DONE).
- One sub-module, sa_skew_line: a parameterised-depth 8-bit delay line with async reset. Instantiated for row2 (depth 1) and row3 (depth 2), with one extra stage for all rows to provide the registered output.

Test Plan:
- Reset/idle: assert reset, then release -> all outputs 0, vec_ready=0; write addr 4 = 0x07 -> weight_out_2_2=0x07 next cycle, others 0.
- Skew: start, then vector {0x03,0x02,0x01} accepted at edge k with vec_last -> subject_out_1=0x01 @k+1, subject_out_2=0x02 @k+2, subject_out_3=0x03 @k+3; zeros elsewhere.
- Latency/tagging (bench stub drives sa_result = cycle count): 4 back-to-back vectors -> result_valid high for exactly 4 consecutive cycles starting k+6, result_data tracks sa_result; done pulse 1 cycle after the last result_valid.
- Bubbles: vec_valid pattern 1,0,1 -> result_valid pattern 1,0,1 with the same spacing; the bubble cycle shows subject_out_1=0.
- Illegal writes: weight write with addr=9 in IDLE -> no change; write while busy -> no change; start during STREAM -> ignored.
- Reset mid-job: assert reset 2 cycles after the first handshake -> all outputs 0 immediately, no result_valid, no done; a fresh job after release behaves as in the skew test.
